// File: rtl/i2c_pkg.sv
// Shared I2C definitions: byte width and the word packer state encoding.
// Also used by the receive stage so both sides agree on the byte width.
package i2c_pkg;

   localparam int I2C_BYTE_W = 8;

   typedef enum logic [1:0] {
      PK_IDLE = 2'd0,
      PK_ACC  = 2'd1,
      PK_FULL = 2'd2
   } pk_state_e;

endpackage

// File: rtl/i2c_rx_word_packer_if.sv
// Packed-word output bus of the I2C receive word packer.
// The producer (master) drives the word, and the consumer (slave) returns ready.
interface i2c_rx_word_packer_if
   import i2c_pkg::*;
#(
   parameter int WORD_BYTES = 4
) ();

   localparam int W = I2C_BYTE_W * WORD_BYTES;

   logic [W-1:0]          word_data;
   logic [WORD_BYTES-1:0] word_keep;
   logic                  word_last;
   logic                  word_valid;
   logic                  word_ready;

   modport master (
      output word_data,
      output word_keep,
      output word_last,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_data,
      input  word_keep,
      input  word_last,
      input  word_valid,
      output word_ready
   );

endinterface

// File: rtl/i2c_strobe_det.sv
// Rising-edge detector on a valid level: one-cycle strobe per low-to-high transition.
// The strobe is asserted during the first cycle in which the level is high.
module i2c_strobe_det (
   input  logic clk,
   input  logic rst_n,
   input  logic valid_in,
   output logic strobe
);

   logic valid_d;
   logic valid_q;

   always_comb begin
      valid_d = valid_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign strobe = valid_in & ~valid_q;

endmodule

// File: rtl/i2c_rx_word_packer.sv
// Packs the I2C receive byte stream into WORD_BYTES-wide words, first byte in the top lane.
// A single output register is backed by one complete word parked in the accumulator.
module i2c_rx_word_packer
   import i2c_pkg::*;
#(
   parameter int WORD_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_start,
   input  logic [I2C_BYTE_W-1:0] rx_data,
   input  logic                  rx_valid,
   input  logic                  rx_last,
   i2c_rx_word_packer_if.master  word_if,
   output logic                  overflow,
   input  logic                  clr_overflow,
   output logic                  busy
);

   localparam int W     = I2C_BYTE_W * WORD_BYTES;
   localparam int IDX_W = (WORD_BYTES > 2) ? $clog2(WORD_BYTES) : 1;

   pk_state_e             state_q, state_d;
   logic [W-1:0]          acc_q, acc_d;
   logic [WORD_BYTES-1:0] keep_q, keep_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  last_q, last_d;
   logic [W-1:0]          out_data_q, out_data_d;
   logic [WORD_BYTES-1:0] out_keep_q, out_keep_d;
   logic                  out_last_q, out_last_d;
   logic                  out_valid_q, out_valid_d;
   logic                  overflow_q, overflow_d;

   logic                  strobe;
   logic                  out_free;
   logic                  complete;
   logic [W-1:0]          base_acc, new_acc;
   logic [WORD_BYTES-1:0] base_keep, new_keep;
   logic [IDX_W-1:0]      base_idx;

   i2c_strobe_det u_strobe_det (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (rx_valid),
      .strobe   (strobe)
   );

   assign out_free = ~out_valid_q | word_if.word_ready;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      keep_d      = keep_q;
      idx_d       = idx_q;
      last_d      = last_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q & ~word_if.word_ready;
      overflow_d  = overflow_q & ~clr_overflow;

      // A restart while accumulating discards the partial word before the new byte lands.
      base_acc  = acc_q;
      base_keep = keep_q;
      base_idx  = idx_q;
      if (state_q == PK_ACC && rx_start) begin
         base_acc  = '0;
         base_keep = '0;
         base_idx  = '0;
      end

      new_acc  = base_acc;
      new_keep = base_keep;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (base_idx == IDX_W'(i)) begin
            new_acc[W-1-I2C_BYTE_W*i -: I2C_BYTE_W] = rx_data;
            new_keep[WORD_BYTES-1-i]                = 1'b1;
         end
      end
      complete = (base_idx == IDX_W'(WORD_BYTES - 1)) | rx_last;

      case (state_q)
         PK_IDLE, PK_ACC: begin
            acc_d  = base_acc;
            keep_d = base_keep;
            idx_d  = base_idx;
            if (state_q == PK_ACC && rx_start) begin
               state_d = PK_IDLE;
            end
            if (strobe) begin
               if (complete && out_free) begin
                  out_data_d  = new_acc;
                  out_keep_d  = new_keep;
                  out_last_d  = rx_last;
                  out_valid_d = 1'b1;
                  acc_d       = '0;
                  keep_d      = '0;
                  idx_d       = '0;
                  last_d      = 1'b0;
                  state_d     = PK_IDLE;
               end else if (complete) begin
                  acc_d   = new_acc;
                  keep_d  = new_keep;
                  idx_d   = '0;
                  last_d  = rx_last;
                  state_d = PK_FULL;
               end else begin
                  acc_d   = new_acc;
                  keep_d  = new_keep;
                  idx_d   = base_idx + 1'b1;
                  state_d = PK_ACC;
               end
            end
         end
         PK_FULL: begin
            if (strobe) begin
               overflow_d = 1'b1;
            end
            if (out_free) begin
               out_data_d  = acc_q;
               out_keep_d  = keep_q;
               out_last_d  = last_q;
               out_valid_d = 1'b1;
               acc_d       = '0;
               keep_d      = '0;
               idx_d       = '0;
               last_d      = 1'b0;
               state_d     = PK_IDLE;
            end
         end
         default: begin
            state_d = PK_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PK_IDLE;
         acc_q       <= '0;
         keep_q      <= '0;
         idx_q       <= '0;
         last_q      <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         keep_q      <= keep_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign word_if.word_data  = out_data_q;
   assign word_if.word_keep  = out_keep_q;
   assign word_if.word_last  = out_last_q;
   assign word_if.word_valid = out_valid_q;
   assign overflow           = overflow_q;
   assign busy               = (state_q != PK_IDLE) | out_valid_q;

endmodule
